// File: rtl/sub_operand_collector.sv
// sub_operand_collector
// Pairs a minuend stream (A channel) with a subtrahend stream (B channel) for a
// downstream subtractor. Each channel is buffered in a small in-order FIFO. A
// registered A/B/op_valid output slot uses a valid/ready handshake.
//
// Build option: define SUB_OPCOLL_PERF_EN to add the pair_count output. It is a
// 16-bit wrapping count of output handshakes that only reset clears.
module sub_operand_collector #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         a_in,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [WIDTH-1:0]         b_in,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         A,
  output logic [WIDTH-1:0]         B,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [$clog2(DEPTH):0]   a_count,
  output logic [$clog2(DEPTH):0]   b_count
`ifdef SUB_OPCOLL_PERF_EN
  ,
  output logic [15:0]              pair_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NCH = 2;

  // Channel 0 carries the minuend and channel 1 carries the subtrahend.
  // Packing both channels lets one generate body describe both FIFOs.
  logic [NCH-1:0][WIDTH-1:0] ch_data;
  logic [NCH-1:0]            ch_valid;
  logic [NCH-1:0]            ch_ready;
  logic [NCH-1:0][WIDTH-1:0] ch_head;
  logic [NCH-1:0][CW-1:0]    ch_count;

  // Output slot state
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_valid_q, op_valid_d;

  // A pair leaves the FIFOs when both channels hold data and the slot is free.
  // A slot counts as free when it is empty or is being consumed on this edge.
  // A flush cancels the pair leaving the FIFOs.
  logic fire;

  assign ch_data[0]  = a_in;
  assign ch_data[1]  = b_in;
  assign ch_valid[0] = a_valid;
  assign ch_valid[1] = b_valid;

  assign fire = (ch_count[0] != '0) && (ch_count[1] != '0) &&
                (!op_valid_q || op_ready) && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
      logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
      logic [CW-1:0]    count_q, count_d;
      logic             push;
      logic             pop;

      // The ready output depends only on registered state and on reset.
      // It never depends on the valids or on op_ready.
      assign ch_ready[gi] = rst_n && (count_q < CW'(DEPTH));

      // A full FIFO refuses data even when it pops on the same edge.
      // The check uses count_q, so that case needs no extra logic.
      assign push = ch_valid[gi] && ch_ready[gi] && !flush;
      assign pop  = fire;

      // Next pointer and occupancy. Pointers wrap explicitly at DEPTH-1.
      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
          end
          if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
          end
          count_d = count_q + CW'(push) - CW'(pop);
        end
      end

      // Register the pointers and the occupancy. Reset clears all three.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      // Write the storage array. It has no reset so it can map to RAM.
      always_ff @(posedge clk) begin
        if (push) begin
          mem_q[wr_ptr_q] <= ch_data[gi];
        end
      end

      assign ch_head[gi]  = mem_q[rd_ptr_q];
      assign ch_count[gi] = count_q;
    end
  endgenerate

  assign a_ready = ch_ready[0];
  assign b_ready = ch_ready[1];
  assign a_count = ch_count[0];
  assign b_count = ch_count[1];

  // Next state of the output slot.
  // On fire, load the FIFO heads.
  // On a consume with no fire, empty the slot.
  // On a stall, hold the slot.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    op_valid_d = op_valid_q;
    if (flush) begin
      op_valid_d = 1'b0;
    end else if (fire) begin
      a_d        = ch_head[0];
      b_d        = ch_head[1];
      op_valid_d = 1'b1;
    end else if (op_valid_q && op_ready) begin
      op_valid_d = 1'b0;
    end
  end

  // Register the output slot. Reset zeroes the operands and the valid flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_valid_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign op_valid = op_valid_q;

`ifdef SUB_OPCOLL_PERF_EN
  logic [15:0] pair_count_q, pair_count_d;

  // Count every output handshake. A flush does not clear the count.
  always_comb begin
    pair_count_d = pair_count_q;
    if (op_valid_q && op_ready) begin
      pair_count_d = pair_count_q + 16'd1;
    end
  end

  // Register the handshake counter. Only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pair_count_q <= '0;
    end else begin
      pair_count_q <= pair_count_d;
    end
  end

  assign pair_count = pair_count_q;
`endif

endmodule
